// File: rtl/mem_arbiter.sv
// Instruction/data line-fill arbiter in front of a fixed-latency memory port.
// Optional macro ARB_ROUND_ROBIN_EN alternates tie-breaks; otherwise D wins every tie.
module mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_SIZE   = 64,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_grant,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_grant,
  output logic                 d_done,
  output logic [LINE_SIZE-1:0] rdata,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [LINE_SIZE-1:0] mem_data,
  output logic                 busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             own_d;
  logic             we_q;
  logic             pick_d;
  logic             accept;
  logic             last_xfer;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // On a tie the side that did not win the previous acceptance goes first.
  assign pick_d = d_req && !(i_req && last_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_d <= 1'b1;
    else if (accept) last_d <= pick_d;
  end
`else
  assign pick_d = d_req;
`endif

  assign accept    = (state == IDLE) && (i_req || d_req);
  assign last_xfer = (state == XFER) && (cnt == CNT_W'(MEM_LATENCY - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nx = XFER;
      XFER:    if (last_xfer)      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt <= '0;
    else if (state == XFER)  cnt <= cnt + 1'b1;
    else                     cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_d       <= 1'b0;
      we_q        <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
    end else begin
      if (accept) begin
        own_d       <= pick_d;
        we_q        <= pick_d && d_we;
        mem_address <= pick_d ? d_addr : i_addr;
        if (pick_d) mem_wdata <= d_wdata;
      end
      if (last_xfer && !we_q) rdata <= mem_data;
    end
  end

  // Outputs decode directly from registered state, so reset clears them without waiting for a clock.
  assign busy       = (state != IDLE);
  assign mem_readM  = (state == XFER) && !we_q;
  assign mem_writeM = (state == XFER) &&  we_q;
  assign i_grant    = (state == XFER) && (cnt == '0) && !own_d;
  assign d_grant    = (state == XFER) && (cnt == '0) &&  own_d;
  assign i_done     = (state == DONE) && !own_d;
  assign d_done     = (state == DONE) &&  own_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int ML = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [63:0] mem_data;

  logic        i_grant, i_done, d_grant, d_done, mem_readM, mem_writeM, busy;
  logic [63:0] rdata;
  logic [15:0] mem_address, mem_wdata;

  logic        i_grant_1, i_done_1, d_grant_1, d_done_1, mem_readM_1, mem_writeM_1, busy_1;
  logic [63:0] rdata_1;
  logic [15:0] mem_address_1, mem_wdata_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(16), .LINE_SIZE(64), .MEM_LATENCY(ML)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_done(d_done), .rdata(rdata),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .busy(busy)
  );

  mem_arbiter #(.WORD_SIZE(16), .LINE_SIZE(64), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant_1), .i_done(i_done_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant_1), .d_done(d_done_1), .rdata(rdata_1),
    .mem_readM(mem_readM_1), .mem_writeM(mem_writeM_1),
    .mem_address(mem_address_1), .mem_wdata(mem_wdata_1),
    .mem_data(mem_data), .busy(busy_1)
  );

  // Reference model: a transaction is a timeline of offsets from its acceptance edge.
  // Offset 1 = grant, 1..ML = strobe, ML+1 = done, then one idle cycle before the next accept.
  bit          m_active;
  int          m_k;
  bit          m_own_d, m_we, m_last_d;
  logic [63:0] m_rdata;
  logic [15:0] m_addr, m_wdata;

  function automatic bit winner_is_d(bit ir, bit dr, bit last_d);
    if (ir && dr) return RR ? !last_d : 1'b1;
    return dr;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_own_d  <= 1'b0;
      m_we     <= 1'b0;
      m_last_d <= 1'b1;
      m_rdata  <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else if (!m_active) begin
      if (i_req || d_req) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_own_d  <= winner_is_d(i_req, d_req, m_last_d);
        m_last_d <= winner_is_d(i_req, d_req, m_last_d);
        m_we     <= winner_is_d(i_req, d_req, m_last_d) && d_we;
        m_addr   <= winner_is_d(i_req, d_req, m_last_d) ? d_addr : i_addr;
        if (winner_is_d(i_req, d_req, m_last_d)) m_wdata <= d_wdata;
      end
    end else begin
      if (m_k == ML && !m_we) m_rdata <= mem_data;
      if (m_k == ML + 1) m_active <= 1'b0;
      else               m_k <= m_k + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 30 && busy; n++) @(negedge clk);
    check(name, busy, 1'b0);
  endtask

  typedef struct {
    logic        ir, dr, dwe;
    logic [15:0] ia, da, dw;
    logic [1:0]  exp_g;     // {i_grant, d_grant}
    logic [1:0]  exp_strb;  // {mem_readM, mem_writeM}
    logic [15:0] exp_addr;
  } vec_t;

  vec_t tbl[6];

  task automatic run_row(input vec_t v, input int idx);
    int n;
    i_req = v.ir; d_req = v.dr; d_we = v.dwe;
    i_addr = v.ia; d_addr = v.da; d_wdata = v.dw;
    @(negedge clk);
    check($sformatf("row%0d_grant", idx), {i_grant, d_grant}, v.exp_g);
    i_req = 1'b0; d_req = 1'b0;
    if (v.exp_g == 2'b00) begin
      check($sformatf("row%0d_idle", idx), busy, 1'b0);
      return;
    end
    check($sformatf("row%0d_strobe", idx), {mem_readM, mem_writeM}, v.exp_strb);
    check($sformatf("row%0d_addr", idx), mem_address, v.exp_addr);
    if (v.exp_strb == 2'b01) check($sformatf("row%0d_wdata", idx), mem_wdata, v.dw);
    n = 0;
    while (!(i_done || d_done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("row%0d_done_lat", idx), n, ML);
    check($sformatf("row%0d_done_owner", idx), {i_done, d_done}, v.exp_g);
    @(negedge clk);
    check($sformatf("row%0d_back_idle", idx), busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] saved;
    logic [3:0]  order;
    int          t[$];
    int          n_ig, n_dd, n_id, g_at, d_at;

    tbl[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 2'b10, 2'b10, 16'h0010};
    tbl[1] = '{0, 1, 1, 16'h0000, 16'h0020, 16'hBEEF, 2'b01, 2'b01, 16'h0020};
    tbl[2] = RR ? '{1, 1, 1, 16'h0100, 16'h0200, 16'h1234, 2'b10, 2'b10, 16'h0100}
                : '{1, 1, 1, 16'h0100, 16'h0200, 16'h1234, 2'b01, 2'b01, 16'h0200};
    tbl[3] = '{0, 1, 0, 16'h0400, 16'h0300, 16'h0000, 2'b01, 2'b10, 16'h0300};
    tbl[4] = RR ? '{1, 1, 0, 16'h0500, 16'h0600, 16'h0000, 2'b10, 2'b10, 16'h0500}
                : '{1, 1, 0, 16'h0500, 16'h0600, 16'h0000, 2'b01, 2'b10, 16'h0600};
    tbl[5] = '{0, 0, 0, 16'h0700, 16'h0800, 16'h0000, 2'b00, 2'b00, 16'h0000};

    mem_data = 64'h1111_2222_3333_4444;
    do_reset();
    check("reset_ctl", {i_grant, i_done, d_grant, d_done, mem_readM, mem_writeM, busy}, 7'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_addr", mem_address, 16'd0);
    check("reset_wdata", mem_wdata, 16'd0);

    // Latency 1: one strobe cycle, done the cycle after.
    i_req = 1'b1; i_addr = 16'h0099;
    @(negedge clk);
    check("ml1_grant_strobe", {i_grant_1, mem_readM_1, mem_writeM_1}, 3'b110);
    i_req = 1'b0;
    @(negedge clk);
    check("ml1_done", {mem_readM_1, i_done_1, i_grant_1}, 3'b010);
    check("ml1_rdata", rdata_1, 64'h1111_2222_3333_4444);
    @(negedge clk);
    check("ml1_idle", busy_1, 1'b0);
    wait_idle("ml1_main_idle");

    foreach (tbl[r]) run_row(tbl[r], r);

    // Instruction line fill: rdata captures the line presented in the last strobe cycle.
    i_req = 1'b1; i_addr = 16'h0010;
    for (int k = 1; k <= ML; k++) begin
      @(negedge clk);
      if (k == 1) check("ifill_grant", i_grant, 1'b1);
      i_req = 1'b0;
      check($sformatf("ifill_strobe%0d", k), {mem_readM, mem_writeM, mem_address}, {2'b10, 16'h0010});
      mem_data = 64'hA5A5_0000_0000_0000 | 64'(k);
    end
    @(negedge clk);
    check("ifill_done", {i_done, mem_readM}, 2'b10);
    check("ifill_rdata", rdata, 64'hA5A5_0000_0000_0004);
    @(negedge clk);
    check("ifill_pulse", {i_done, busy}, 2'b00);

    // Data write: rdata keeps the previous line, no read strobe.
    saved = rdata;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
    for (int k = 1; k <= ML; k++) begin
      @(negedge clk);
      d_req = 1'b0;
      mem_data = {$urandom, $urandom};
      check($sformatf("dwr_strobe%0d", k), {mem_readM, mem_writeM, mem_wdata}, {2'b01, 16'hBEEF});
    end
    @(negedge clk);
    check("dwr_done", {d_done, mem_writeM, mem_readM}, 3'b100);
    @(negedge clk);
    check("dwr_rdata_kept", rdata, saved);
    d_we = 1'b0;

    // Both requests held continuously from a fresh reset.
    do_reset();
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0111; d_addr = 16'h0222;
    order = '0;
    for (int c = 0; c < 40 && t.size() < 4; c++) begin
      @(negedge clk);
      if (i_grant || d_grant) begin
        order = {order[2:0], d_grant};
        t.push_back(c);
      end
    end
    check("tie_grant_count", t.size(), 4);
    check("tie_grant_order", order, RR ? 4'b0101 : 4'b1111);
    for (int j = 1; j < t.size(); j++) check($sformatf("tie_spacing%0d", j), t[j] - t[j-1], ML + 2);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    wait_idle("tie_drain");

    // Reset in the second XFER cycle aborts the write.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5555;
    @(negedge clk);
    check("abort_grant", d_grant, 1'b1);
    d_req = 1'b0;
    @(negedge clk);
    check("abort_xfer2", mem_writeM, 1'b1);
    #1 reset = 1'b1;
    #1 check("abort_async", {mem_readM, mem_writeM, busy, d_grant, d_done}, 5'd0);
    check("abort_addr", mem_address, 16'd0);
    @(negedge clk);
    reset = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 16'h0070;
    n_dd = 0; n_id = 0; g_at = -1; d_at = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_dd += int'(d_done);
      n_id += int'(i_done);
      if (i_grant) begin g_at = c; i_req = 1'b0; end
      if (i_done)  d_at = c;
    end
    check("abort_no_d_done", n_dd, 0);
    check("abort_fresh_i_done", n_id, 1);
    check("abort_fresh_latency", d_at - g_at, ML);

    // I pulse while D is in XFER is never granted.
    wait_idle("pulse_pre_idle");
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
    @(negedge clk);
    check("pulse_d_grant", d_grant, 1'b1);
    d_req = 1'b0;
    n_ig = 0; n_dd = 0;
    for (int j = 0; j < 10; j++) begin
      if (j == 0) begin i_req = 1'b1; i_addr = 16'h0F00; end
      if (j == 1) i_req = 1'b0;
      @(negedge clk);
      n_ig += int'(i_grant);
      n_dd += int'(d_done);
    end
    check("pulse_no_i_grant", n_ig, 0);
    check("pulse_d_done", n_dd, 1);
    check("pulse_addr_held", mem_address, 16'h0080);

    // Randomized traffic against the timeline model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      check("rnd_ctl",
            {i_grant, i_done, d_grant, d_done, mem_readM, mem_writeM, busy},
            {m_active && m_k == 1 && !m_own_d,
             m_active && m_k == ML + 1 && !m_own_d,
             m_active && m_k == 1 && m_own_d,
             m_active && m_k == ML + 1 && m_own_d,
             m_active && m_k <= ML && !m_we,
             m_active && m_k <= ML && m_we,
             m_active});
      check("rnd_rdata", rdata, m_rdata);
      check("rnd_addr", mem_address, m_addr);
      check("rnd_wdata", mem_wdata, m_wdata);
      i_req    = ($urandom % 3) != 0;
      d_req    = ($urandom % 3) != 0;
      d_we     = $urandom % 2;
      i_addr   = 16'($urandom);
      d_addr   = 16'($urandom);
      d_wdata  = 16'($urandom);
      mem_data = {$urandom, $urandom};
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
